// File: rtl/gf180mcu_fd_sc_mcu9t5v0__dffnr_pipe_pkg.sv
// Shared bounds and helpers for the falling-edge elastic register pipeline.
package gf180mcu_fd_sc_mcu9t5v0__dffnr_pipe_pkg;

  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 64;
  localparam int DEPTH_MIN = 1;
  localparam int DEPTH_MAX = 16;

  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned popcount(input logic [DEPTH_MAX-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < DEPTH_MAX; i++) n += {31'd0, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__dffnr_pipe_stage.sv
// One pipeline stage: data + valid register, falling-edge load enable, async high reset.
module gf180mcu_fd_sc_mcu9t5v0__dffnr_pipe_stage #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_n_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             v_i,
  output logic [WIDTH-1:0] d_o,
  output logic             v_o
);

  logic [WIDTH-1:0] d_q;
  logic             v_q;

  always_ff @(negedge clk_n_i or posedge rst_i) begin
    if (rst_i) begin
      d_q <= RST_VAL;
      v_q <= 1'b0;
    end else if (en_i) begin
      d_q <= d_i;
      v_q <= v_i;
    end
  end

  assign d_o = d_q;
  assign v_o = v_q;

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__dffnr_pipe.sv
// Falling-edge elastic pipeline of DEPTH stages with valid/ready at each end and live occupancy.
// Optional GF180MCU_FD_SC_MCU9T5V0_NOTIFIER_EN adds a notifier input that X-corrupts state until reset.
module gf180mcu_fd_sc_mcu9t5v0__dffnr_pipe
  import gf180mcu_fd_sc_mcu9t5v0__dffnr_pipe_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                      CLKN,
  input  logic                      R,
  input  logic [WIDTH-1:0]          D,
  input  logic                      DV,
  output logic                      DR,
  output logic [WIDTH-1:0]          Q,
  output logic                      QV,
  input  logic                      QR,
  output logic [occ_w(DEPTH)-1:0]   OCC
`ifdef GF180MCU_FD_SC_MCU9T5V0_NOTIFIER_EN
  ,
  input  logic                      notifier
`endif
);

  localparam int OCC_W = occ_w(DEPTH);

  logic [DEPTH-1:0]            rdy, en, vld, vld_in, vld_d;
  logic [DEPTH-1:0][WIDTH-1:0] dat, dat_in;
  logic [DEPTH_MAX-1:0]        vld_ext;
  logic [OCC_W-1:0]            occ_q, occ_d;
  logic                        corrupt;

`ifdef GF180MCU_FD_SC_MCU9T5V0_NOTIFIER_EN
  // Notifier level is sampled at reset; any later difference poisons state until the next reset.
  logic notif_ref_q, corrupt_q;
  always_ff @(negedge CLKN or posedge R) begin
    if (R) begin
      notif_ref_q <= notifier;
      corrupt_q   <= 1'b0;
    end else if (notifier != notif_ref_q) begin
      corrupt_q   <= 1'b1;
    end
  end
  assign corrupt = corrupt_q || (notifier != notif_ref_q);
`else
  assign corrupt = 1'b0;
`endif

  // Ready ripples from the output back toward D so bubbles collapse in one edge.
  always_comb begin
    rdy            = '0;
    rdy[DEPTH-1]   = !vld[DEPTH-1] || QR;
    for (int i = DEPTH-2; i >= 0; i--) rdy[i] = !vld[i] || rdy[i+1];
    dat_in    = '0;
    vld_in    = '0;
    dat_in[0] = D;
    vld_in[0] = DV;
    for (int i = 1; i < DEPTH; i++) begin
      dat_in[i] = dat[i-1];
      vld_in[i] = vld[i-1];
    end
    en = rdy;
    for (int i = 0; i < DEPTH; i++) vld_d[i] = rdy[i] ? vld_in[i] : vld[i];
    if (corrupt) begin
      en     = '1;
      dat_in = 'x;
      vld_in = 'x;
      vld_d  = 'x;
    end
    vld_ext             = '0;
    vld_ext[DEPTH-1:0]  = vld_d;
    occ_d = corrupt ? 'x : OCC_W'(popcount(vld_ext));
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    gf180mcu_fd_sc_mcu9t5v0__dffnr_pipe_stage #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_stage (
      .clk_n_i (CLKN),
      .rst_i   (R),
      .en_i    (en[i]),
      .d_i     (dat_in[i]),
      .v_i     (vld_in[i]),
      .d_o     (dat[i]),
      .v_o     (vld[i])
    );
  end

  always_ff @(negedge CLKN or posedge R) begin
    if (R) occ_q <= '0;
    else   occ_q <= occ_d;
  end

  assign DR  = rdy[0];
  assign Q   = corrupt ? 'x : dat[DEPTH-1];
  assign QV  = corrupt ? 1'bx : vld[DEPTH-1];
  assign OCC = corrupt ? 'x : occ_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__dffnr_pipe.sv
// Directed bench for the falling-edge elastic pipeline (DEPTH=4, WIDTH=8, RST_VAL=8'hA5).
module tb_gf180mcu_fd_sc_mcu9t5v0__dffnr_pipe;

  logic       CLKN = 1'b1;
  logic       R = 1'b0;
  logic [7:0] D = 8'h00;
  logic       DV = 1'b0;
  logic       DR;
  logic [7:0] Q;
  logic       QV;
  logic       QR = 1'b0;
  logic [2:0] OCC;
`ifdef GF180MCU_FD_SC_MCU9T5V0_NOTIFIER_EN
  logic       notifier = 1'b0;
`endif

  int n_chk = 0;
  int n_err = 0;

  gf180mcu_fd_sc_mcu9t5v0__dffnr_pipe #(
    .WIDTH   (8),
    .DEPTH   (4),
    .RST_VAL (8'hA5)
  ) dut (
    .CLKN (CLKN),
    .R    (R),
    .D    (D),
    .DV   (DV),
    .DR   (DR),
    .Q    (Q),
    .QV   (QV),
    .QR   (QR),
    .OCC  (OCC)
`ifdef GF180MCU_FD_SC_MCU9T5V0_NOTIFIER_EN
    ,
    .notifier (notifier)
`endif
  );

  always #5 CLKN = ~CLKN;

  // One falling edge, then settle just after the following rising edge.
  task automatic cyc();
    @(negedge CLKN);
    @(posedge CLKN);
    #1;
  endtask

  task automatic pulse_reset();
    R = 1'b1;
    #1;
    R = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge CLKN);
    #1;
    R = 1'b1;
    #1;
    n_chk++; if (Q !== 8'hA5) begin n_err++; $display("FAIL reset_q got %h want a5", Q); end
    n_chk++; if (QV !== 1'b0) begin n_err++; $display("FAIL reset_qv got %b want 0", QV); end
    n_chk++; if (OCC !== 3'd0) begin n_err++; $display("FAIL reset_occ got %0d want 0", OCC); end
    n_chk++; if (DR !== 1'b1) begin n_err++; $display("FAIL reset_dr got %b want 1", DR); end
    R = 1'b0;
  endtask

  task automatic test_stream();
    logic [2:0] eocc;
    pulse_reset();
    QR = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      DV = (e <= 8);
      D  = 8'(e);
      cyc();
      eocc = (e <= 3) ? 3'(e) : (e <= 8) ? 3'd4 : 3'(12 - e);
      n_chk++; if (QV !== (e >= 4 && e <= 11)) begin n_err++; $display("FAIL stream_qv edge %0d got %b", e, QV); end
      n_chk++; if (OCC !== eocc) begin n_err++; $display("FAIL stream_occ edge %0d got %0d want %0d", e, OCC, eocc); end
      n_chk++; if (DR !== 1'b1) begin n_err++; $display("FAIL stream_dr edge %0d got %b want 1", e, DR); end
      if (e >= 4 && e <= 11) begin
        n_chk++; if (Q !== 8'(e - 3)) begin n_err++; $display("FAIL stream_q edge %0d got %h want %h", e, Q, 8'(e - 3)); end
      end
    end
    DV = 1'b0;
  endtask

  task automatic test_backpressure();
    pulse_reset();
    QR = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      DV = 1'b1;
      D  = 8'(e);
      cyc();
    end
    D = 8'h05;
    n_chk++; if (OCC !== 3'd4) begin n_err++; $display("FAIL bp_full_occ got %0d want 4", OCC); end
    n_chk++; if (DR !== 1'b0) begin n_err++; $display("FAIL bp_full_dr got %b want 0", DR); end
    cyc();
    n_chk++; if (Q !== 8'h01) begin n_err++; $display("FAIL bp_hold_q got %h want 01", Q); end
    n_chk++; if (OCC !== 3'd4) begin n_err++; $display("FAIL bp_hold_occ got %0d want 4", OCC); end
    QR = 1'b1;
    #1;
    n_chk++; if (DR !== 1'b1) begin n_err++; $display("FAIL bp_dr_comb got %b want 1", DR); end
    cyc();
    DV = 1'b0;
    n_chk++; if (Q !== 8'h02) begin n_err++; $display("FAIL bp_swap_q got %h want 02", Q); end
    n_chk++; if (OCC !== 3'd4) begin n_err++; $display("FAIL bp_swap_occ got %0d want 4", OCC); end
    for (int k = 3; k <= 5; k++) begin
      cyc();
      n_chk++; if (Q !== 8'(k) || QV !== 1'b1) begin n_err++; $display("FAIL bp_drain q=%h qv=%b want %h/1", Q, QV, 8'(k)); end
    end
    cyc();
    n_chk++; if (QV !== 1'b0 || OCC !== 3'd0) begin n_err++; $display("FAIL bp_empty qv=%b occ=%0d want 0/0", QV, OCC); end
  endtask

  task automatic test_bubble();
    pulse_reset();
    QR = 1'b0;
    DV = 1'b1; D = 8'h11; cyc();
    DV = 1'b0; cyc(); cyc();
    DV = 1'b1; D = 8'h22; cyc();
    DV = 1'b0; cyc(); cyc(); cyc();
    n_chk++; if (OCC !== 3'd2) begin n_err++; $display("FAIL bubble_occ got %0d want 2", OCC); end
    n_chk++; if (Q !== 8'h11 || QV !== 1'b1) begin n_err++; $display("FAIL bubble_q got %h/%b want 11/1", Q, QV); end
    n_chk++; if (DR !== 1'b1) begin n_err++; $display("FAIL bubble_dr got %b want 1", DR); end
    // Items packed into stages 3 and 2: draining yields them back to back.
    QR = 1'b1;
    cyc();
    n_chk++; if (Q !== 8'h22 || QV !== 1'b1 || OCC !== 3'd1) begin n_err++; $display("FAIL bubble_next q=%h qv=%b occ=%0d want 22/1/1", Q, QV, OCC); end
    cyc();
    n_chk++; if (QV !== 1'b0 || OCC !== 3'd0) begin n_err++; $display("FAIL bubble_empty qv=%b occ=%0d want 0/0", QV, OCC); end
  endtask

  task automatic test_reset_midop();
    pulse_reset();
    QR = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      DV = 1'b1; D = 8'(8'h30 + e); cyc();
    end
    DV = 1'b0;
    n_chk++; if (OCC !== 3'd3) begin n_err++; $display("FAIL mid_pre_occ got %0d want 3", OCC); end
    R = 1'b1;
    #1;
    n_chk++; if (OCC !== 3'd0 || QV !== 1'b0 || DR !== 1'b1) begin n_err++; $display("FAIL mid_async occ=%0d qv=%b dr=%b want 0/0/1", OCC, QV, DR); end
    DV = 1'b1; D = 8'h77;
    cyc();
    n_chk++; if (OCC !== 3'd0 || QV !== 1'b0) begin n_err++; $display("FAIL mid_held occ=%0d qv=%b want 0/0", OCC, QV); end
    R = 1'b0;
    QR = 1'b1;
    D = 8'h41;
    for (int e = 1; e <= 5; e++) begin
      cyc();
      DV = 1'b0;
      n_chk++; if (QV !== (e == 4)) begin n_err++; $display("FAIL mid_qv edge %0d got %b", e, QV); end
      n_chk++; if (OCC !== ((e <= 4) ? 3'd1 : 3'd0)) begin n_err++; $display("FAIL mid_occ edge %0d got %0d", e, OCC); end
    end
    n_chk++; if (Q !== 8'h41) begin n_err++; $display("FAIL mid_q got %h want 41", Q); end
  endtask

`ifdef GF180MCU_FD_SC_MCU9T5V0_NOTIFIER_EN
  task automatic test_notifier();
    pulse_reset();
    QR = 1'b0;
    DV = 1'b1; D = 8'h55; cyc(); cyc();
    DV = 1'b0;
    notifier = ~notifier;
    #1;
    n_chk++; if (!$isunknown(Q) || !$isunknown(QV) || !$isunknown(OCC)) begin n_err++; $display("FAIL notif_x q=%h qv=%b occ=%0d", Q, QV, OCC); end
    pulse_reset();
    n_chk++; if (Q !== 8'hA5 || QV !== 1'b0 || OCC !== 3'd0) begin n_err++; $display("FAIL notif_rst q=%h qv=%b occ=%0d", Q, QV, OCC); end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_bubble();
    test_reset_midop();
`ifdef GF180MCU_FD_SC_MCU9T5V0_NOTIFIER_EN
    test_notifier();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
